// File: rtl/key_bank_pkg.sv
// Shared types and record format for the key bank loader.
// A record is four bytes: header, key index, sequence number, XOR check byte.
package key_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [7:0] REC_HDR   = 8'hA5;
    localparam int         REC_BYTES = 4;

    function automatic logic [7:0] rec_byte(input logic [1:0] idx,
                                            input logic [2:0] key,
                                            input logic [7:0] seq);
        logic [7:0] b;
        case (idx)
            2'd0:    b = REC_HDR;
            2'd1:    b = {5'b0, key};
            2'd2:    b = seq;
            default: b = REC_HDR ^ {5'b0, key} ^ seq;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-flop synchroniser, stability counter, debounced level.
// press pulses for one cycle on the edge where the debounced level falls.
module key_debounce #(
    parameter int DEB_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_CYC);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Reset to the released level so no spurious press follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CNT_W'(DEB_CYC - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                    press <= ~sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/key_bank_loader.sv
// Debounces a bank of keys and logs each press as a 4-byte record into a RAM ring.
// Handshake: none; press events are captured into per-key pending flags in every state.
module key_bank_loader
    import key_bank_pkg::*;
#(
    parameter int                N_KEYS     = 4,
    parameter int                DEB_CYC    = 1000000,
    parameter int                RING_DEPTH = 16,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_bus,
    input  logic              clr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              busy,
    output logic [8:0]        rec_count,
    output logic              ovf,
    output state_t            dbg_state
);

    localparam int PTR_W = $clog2(RING_DEPTH);

    state_t            state;
    state_t            state_next;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] pending;
    logic [N_KEYS-1:0] lowest;
    logic [N_KEYS-1:0] grant;
    logic [2:0]        grant_idx;
    logic              start_wr;
    logic              do_clear;
    logic              ovf_event;
    logic              clr_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [7:0]        seq;
    logic [2:0]        key_idx;
    logic [1:0]        byte_idx;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_deb
        key_debounce #(
            .DEB_CYC(DEB_CYC)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .key_n(key_bus[k]),
            .press(press[k])
        );
    end

    // Lowest set pending bit, both one-hot and as an index.
    assign lowest = pending & (~pending + 1'b1);

    always_comb begin
        grant_idx = 3'd0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (pending[i]) grant_idx = 3'(i);
        end
    end

    always_comb begin
        state_next = state;
        start_wr   = 1'b0;
        do_clear   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clr_q) begin
                    state_next = ST_CLEAR;
                    do_clear   = 1'b1;
                end else if (|pending) begin
                    state_next = ST_WRITE;
                    start_wr   = 1'b1;
                end
            end
            ST_WRITE: begin
                if (byte_idx == 2'(REC_BYTES - 1)) state_next = ST_IDLE;
            end
            ST_CLEAR: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign grant     = start_wr ? lowest : '0;
    assign ovf_event = |(press & pending & ~grant);
    assign busy      = (state == ST_WRITE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            clr_q     <= 1'b0;
            ovf       <= 1'b0;
            wr_ptr    <= '0;
            seq       <= 8'd0;
            rec_count <= 9'd0;
            key_idx   <= 3'd0;
            byte_idx  <= 2'd0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_din   <= 8'd0;
        end else begin
            pending <= (pending & ~grant) | press;

            if (do_clear)  clr_q <= clr;
            else if (clr)  clr_q <= 1'b1;

            // A press lost on the clearing cycle is still reported.
            if (ovf_event)     ovf <= 1'b1;
            else if (do_clear) ovf <= 1'b0;

            if (do_clear) begin
                wr_ptr    <= '0;
                seq       <= 8'd0;
                rec_count <= 9'd0;
            end

            if (start_wr) begin
                key_idx  <= grant_idx;
                byte_idx <= 2'd0;
                mem_we   <= 1'b1;
                mem_addr <= BASE_ADDR + ADDR_W'({wr_ptr, 2'b00});
                mem_din  <= rec_byte(2'd0, grant_idx, seq);
            end else if (state == ST_WRITE) begin
                if (byte_idx == 2'(REC_BYTES - 1)) begin
                    mem_we <= 1'b0;
                    wr_ptr <= wr_ptr + 1'b1;
                    seq    <= seq + 8'd1;
                    if (rec_count != 9'(RING_DEPTH)) rec_count <= rec_count + 9'd1;
                end else begin
                    byte_idx <= byte_idx + 2'd1;
                    mem_addr <= mem_addr + 1'b1;
                    mem_din  <= rec_byte(byte_idx + 2'd1, key_idx, seq);
                end
            end
        end
    end

endmodule

// File: tb/tb_key_bank_loader.sv
// Directed bench for key_bank_loader with DEB_CYC=4, RING_DEPTH=4, BASE_ADDR=0x100.
// A monitor logs every RAM write; each test compares the log against hand-built expectations.
module tb_key_bank_loader;
    import key_bank_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  key_bus;
    logic        clr;
    logic [31:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic        busy;
    logic [8:0]  rec_count;
    logic        ovf;
    state_t      dbg_state;

    int checks;
    int errors;
    int cyc;

    logic [31:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          wc_q[$];
    logic [31:0] exp_a_q[$];
    logic [7:0]  exp_q[$];

    key_bank_loader #(
        .N_KEYS    (4),
        .DEB_CYC   (4),
        .RING_DEPTH(4),
        .ADDR_W    (32),
        .BASE_ADDR (32'h100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_bus  (key_bus),
        .clr      (clr),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .busy     (busy),
        .rec_count(rec_count),
        .ovf      (ovf),
        .dbg_state(dbg_state)
    );

    // Clock / cycle counter / write monitor
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_din);
            wc_q.push_back(cyc);
        end
    end

    // Driver tasks
    task automatic flush();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        exp_a_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        key_bus = 4'hF;
        clr     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        flush();
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_rec(input logic [31:0] a, input logic [7:0] k,
                            input logic [7:0] s, input logic [7:0] x);
        exp_a_q.push_back(a);        exp_q.push_back(8'hA5);
        exp_a_q.push_back(a + 32'd1); exp_q.push_back(k);
        exp_a_q.push_back(a + 32'd2); exp_q.push_back(s);
        exp_a_q.push_back(a + 32'd3); exp_q.push_back(x);
    endtask

    // Tests
    task automatic test_reset();
        do_reset();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL reset_addr got %h want 100", mem_addr); end
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL reset_din got %h want 00", mem_din); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rec_count !== 9'd0) begin errors++; $display("FAIL reset_count got %0d want 0", rec_count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    endtask

    task automatic test_single_press();
        int c0;
        do_reset();
        c0 = cyc;
        key_bus[2] = 1'b0;
        wait_until(c0 + 9);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        checks++; if (dbg_state !== ST_WRITE) begin errors++; $display("FAIL single_state got %0d want 1", dbg_state); end
        wait_until(c0 + 12);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
        wait_until(c0 + 20);
        key_bus[2] = 1'b1;
        wait_until(c0 + 32);
        push_rec(32'h100, 8'h02, 8'h00, 8'hA7);
        checks++; if (wd_q.size() !== 4) begin errors++; $display("FAIL single_nwr got %0d want 4", wd_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wd_q.size()) begin
                checks++; if (wa_q[i] !== exp_a_q[i]) begin errors++; $display("FAIL single_addr[%0d] got %h want %h", i, wa_q[i], exp_a_q[i]); end
                checks++; if (wd_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_data[%0d] got %h want %h", i, wd_q[i], exp_q[i]); end
            end
        end
        if (wc_q.size() >= 4) begin
            checks++; if (wc_q[0] !== c0 + 8) begin errors++; $display("FAIL single_latency got %0d want %0d", wc_q[0], c0 + 8); end
            checks++; if (wc_q[3] !== c0 + 11) begin errors++; $display("FAIL single_last got %0d want %0d", wc_q[3], c0 + 11); end
        end
        checks++; if (rec_count !== 9'd1) begin errors++; $display("FAIL single_count got %0d want 1", rec_count); end
    endtask

    task automatic test_glitch();
        int c0;
        flush();
        c0 = cyc;
        key_bus[2] = 1'b0;
        wait_until(c0 + 3);
        key_bus[2] = 1'b1;
        wait_until(c0 + 25);
        checks++; if (wd_q.size() !== 0) begin errors++; $display("FAIL glitch_nwr got %0d want 0", wd_q.size()); end
        checks++; if (rec_count !== 9'd1) begin errors++; $display("FAIL glitch_count got %0d want 1", rec_count); end
    endtask

    task automatic test_two_keys();
        int c0;
        do_reset();
        c0 = cyc;
        key_bus = 4'b0110;
        wait_until(c0 + 25);
        key_bus = 4'hF;
        wait_until(c0 + 37);
        push_rec(32'h100, 8'h00, 8'h00, 8'hA5);
        push_rec(32'h104, 8'h03, 8'h01, 8'hA7);
        checks++; if (wd_q.size() !== 8) begin errors++; $display("FAIL two_nwr got %0d want 8", wd_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wd_q.size()) begin
                checks++; if (wa_q[i] !== exp_a_q[i]) begin errors++; $display("FAIL two_addr[%0d] got %h want %h", i, wa_q[i], exp_a_q[i]); end
                checks++; if (wd_q[i] !== exp_q[i]) begin errors++; $display("FAIL two_data[%0d] got %h want %h", i, wd_q[i], exp_q[i]); end
            end
        end
        if (wc_q.size() >= 8) begin
            checks++; if (wc_q[0] !== c0 + 8) begin errors++; $display("FAIL two_latency got %0d want %0d", wc_q[0], c0 + 8); end
            checks++; if (wc_q[4] !== c0 + 13) begin errors++; $display("FAIL two_gap got %0d want %0d", wc_q[4], c0 + 13); end
        end
        checks++; if (rec_count !== 9'd2) begin errors++; $display("FAIL two_count got %0d want 2", rec_count); end
    endtask

    task automatic test_wrap();
        int c0;
        logic [7:0] xtab [5];
        xtab = '{8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA0};
        do_reset();
        for (int r = 0; r < 5; r++) begin
            c0 = cyc;
            key_bus[1] = 1'b0;
            wait_until(c0 + 10);
            key_bus[1] = 1'b1;
            wait_until(c0 + 20);
            push_rec(32'h100 + 32'(4 * (r % 4)), 8'h01, 8'(r), xtab[r]);
        end
        wait_until(cyc + 5);
        checks++; if (wd_q.size() !== 20) begin errors++; $display("FAIL wrap_nwr got %0d want 20", wd_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wd_q.size()) begin
                checks++; if (wa_q[i] !== exp_a_q[i]) begin errors++; $display("FAIL wrap_addr[%0d] got %h want %h", i, wa_q[i], exp_a_q[i]); end
                checks++; if (wd_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, wd_q[i], exp_q[i]); end
            end
        end
        if (wd_q.size() >= 20) begin
            checks++; if (wa_q[16] !== 32'h100) begin errors++; $display("FAIL wrap_fifth_addr got %h want 100", wa_q[16]); end
            checks++; if (wd_q[18] !== 8'h04) begin errors++; $display("FAIL wrap_fifth_seq got %h want 04", wd_q[18]); end
        end
        checks++; if (rec_count !== 9'd4) begin errors++; $display("FAIL wrap_count got %0d want 4", rec_count); end
    endtask

    task automatic test_ovf();
        int c0;
        do_reset();
        c0 = cyc;
        key_bus = 4'b1100;
        wait_until(c0 + 4);
        key_bus[1] = 1'b1;
        wait_until(c0 + 8);
        key_bus[1] = 1'b0;
        wait_until(c0 + 11);
        clr = 1'b1;
        wait_until(c0 + 14);
        clr = 1'b0;
        wait_until(c0 + 30);
        key_bus = 4'hF;
        wait_until(c0 + 42);
        push_rec(32'h100, 8'h00, 8'h00, 8'hA5);
        push_rec(32'h100, 8'h01, 8'h00, 8'hA4);
        checks++; if (wd_q.size() !== 8) begin errors++; $display("FAIL ovf_nwr got %0d want 8", wd_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wd_q.size()) begin
                checks++; if (wa_q[i] !== exp_a_q[i]) begin errors++; $display("FAIL ovf_addr[%0d] got %h want %h", i, wa_q[i], exp_a_q[i]); end
                checks++; if (wd_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_data[%0d] got %h want %h", i, wd_q[i], exp_q[i]); end
            end
        end
        if (wc_q.size() >= 8) begin
            checks++; if (wc_q[4] !== c0 + 17) begin errors++; $display("FAIL ovf_start got %0d want %0d", wc_q[4], c0 + 17); end
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ovf); end
        checks++; if (rec_count !== 9'd1) begin errors++; $display("FAIL ovf_count got %0d want 1", rec_count); end
    endtask

    task automatic test_clr_mid();
        int c0;
        int c1;
        flush();
        c0 = cyc;
        key_bus[2] = 1'b0;
        wait_until(c0 + 9);
        clr = 1'b1;
        wait_until(c0 + 10);
        clr = 1'b0;
        wait_until(c0 + 12);
        checks++; if (rec_count !== 9'd2) begin errors++; $display("FAIL clr_pre_count got %0d want 2", rec_count); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL clr_pre_ovf got %b want 1", ovf); end
        wait_until(c0 + 13);
        checks++; if (dbg_state !== ST_CLEAR) begin errors++; $display("FAIL clr_state got %0d want 2", dbg_state); end
        wait_until(c0 + 14);
        checks++; if (rec_count !== 9'd0) begin errors++; $display("FAIL clr_count got %0d want 0", rec_count); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b want 0", ovf); end
        wait_until(c0 + 20);
        key_bus[2] = 1'b1;
        wait_until(c0 + 32);
        c1 = cyc;
        key_bus[3] = 1'b0;
        wait_until(c1 + 20);
        key_bus[3] = 1'b1;
        wait_until(c1 + 32);
        push_rec(32'h104, 8'h02, 8'h01, 8'hA6);
        push_rec(32'h100, 8'h03, 8'h00, 8'hA6);
        checks++; if (wd_q.size() !== 8) begin errors++; $display("FAIL clr_nwr got %0d want 8", wd_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wd_q.size()) begin
                checks++; if (wa_q[i] !== exp_a_q[i]) begin errors++; $display("FAIL clr_addr[%0d] got %h want %h", i, wa_q[i], exp_a_q[i]); end
                checks++; if (wd_q[i] !== exp_q[i]) begin errors++; $display("FAIL clr_data[%0d] got %h want %h", i, wd_q[i], exp_q[i]); end
            end
        end
        checks++; if (rec_count !== 9'd1) begin errors++; $display("FAIL clr_post_count got %0d want 1", rec_count); end
    endtask

    task automatic test_rst_mid();
        int c0;
        int c1;
        flush();
        c0 = cyc;
        key_bus[1] = 1'b0;
        wait_until(c0 + 10);
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_we got %b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL rstmid_addr got %h want 100", mem_addr); end
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rstmid_din got %h want 00", mem_din); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (rec_count !== 9'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", rec_count); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rstmid_state got %0d want 0", dbg_state); end
        key_bus = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_rec(32'h104, 8'h01, 8'h01, 8'hA5);
        checks++; if (wd_q.size() !== 3) begin errors++; $display("FAIL rstmid_partial got %0d want 3", wd_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < wd_q.size()) begin
                checks++; if (wa_q[i] !== exp_a_q[i]) begin errors++; $display("FAIL rstmid_addr[%0d] got %h want %h", i, wa_q[i], exp_a_q[i]); end
                checks++; if (wd_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_data[%0d] got %h want %h", i, wd_q[i], exp_q[i]); end
            end
        end
        flush();
        repeat (2) @(negedge clk);
        c1 = cyc;
        key_bus[3] = 1'b0;
        wait_until(c1 + 20);
        key_bus[3] = 1'b1;
        wait_until(c1 + 32);
        push_rec(32'h100, 8'h03, 8'h00, 8'hA6);
        checks++; if (wd_q.size() !== 4) begin errors++; $display("FAIL rstpost_nwr got %0d want 4", wd_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wd_q.size()) begin
                checks++; if (wa_q[i] !== exp_a_q[i]) begin errors++; $display("FAIL rstpost_addr[%0d] got %h want %h", i, wa_q[i], exp_a_q[i]); end
                checks++; if (wd_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstpost_data[%0d] got %h want %h", i, wd_q[i], exp_q[i]); end
            end
        end
        checks++; if (rec_count !== 9'd1) begin errors++; $display("FAIL rstpost_count got %0d want 1", rec_count); end
    endtask

    // Sequence and report
    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        rst     = 1'b1;
        key_bus = 4'hF;
        clr     = 1'b0;
        test_reset();
        test_single_press();
        test_glitch();
        test_two_keys();
        test_wrap();
        test_ovf();
        test_clr_mid();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_bank_loader.md
KEY_BANK_LOADER -- requirements
Module: key_bank_loader

Interface
REQ-001 SHALL have parameter N_KEYS, default 4, number of key inputs (1..8).
REQ-002 SHALL have parameter DEB_CYC, default 1000000, stable cycles required to accept a key level (>=2).
REQ-003 SHALL have parameter RING_DEPTH, default 16, record slots in the RAM ring (power of two, 2..256).
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0, RAM byte address of slot 0.
REQ-005 SHALL have parameter ADDR_W, default 32, RAM address width.
REQ-006 SHALL have port clk  input  1  sole clock, RAM port-B clock domain.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port key_bus  input  N_KEYS  raw asynchronous keys, active-low (0 = pressed).
REQ-009 SHALL have port clr  input  1  single-cycle request to empty the ring and clear status.
REQ-010 SHALL have port mem_addr  output  ADDR_W  RAM port-B byte address.
REQ-011 SHALL have port mem_din  output  8  RAM port-B write data.
REQ-012 SHALL have port mem_we  output  1  RAM port-B write enable.
REQ-013 SHALL have port busy  output  1  high while a record is being written.
REQ-014 SHALL have port rec_count  output  9  records held in ring, saturating at RING_DEPTH.
REQ-015 SHALL have port ovf  output  1  sticky: press event lost.

Function
REQ-016 Each key_bus bit SHALL pass a 2-flop synchroniser before any other logic.
REQ-017 Per key: counter resets on any synced/debounced mismatch; debounced level SHALL update once mismatch persists DEB_CYC consecutive cycles.
REQ-018 A press event SHALL be a debounced 1->0 transition; releases generate nothing.
REQ-019 A press event SHALL set that key's pending flag; a press while its flag is already set SHALL be dropped and set ovf.
REQ-020 FSM states: IDLE, WRITE, CLEAR; reset state IDLE.
REQ-021 IDLE->WRITE when any pending flag set and no clear queued; lowest key index wins; its flag clears on the transition cycle.
REQ-022 WRITE SHALL assert mem_we exactly 4 consecutive cycles, bytes in order: 8'hA5, {5'b0,key_idx[2:0]}, seq[7:0], XOR of the three preceding bytes.
REQ-023 First mem_we SHALL occur exactly 2 cycles after the cycle the debounced level registers the press, when FSM is IDLE with no other pending keys.
REQ-024 mem_addr SHALL equal BASE_ADDR + 4*wr_ptr + byte_idx; wr_ptr wraps modulo RING_DEPTH (oldest slot overwritten).
REQ-025 After the 4th byte: wr_ptr+1, seq+1 (8-bit wrap), rec_count+1 saturating at RING_DEPTH; return to IDLE.
REQ-026 Back-to-back pending keys SHALL be served with one IDLE cycle between records (mem_we low exactly 1 cycle).
REQ-027 clr SHALL be latched; honoured from IDLE via CLEAR (1 cycle) zeroing wr_ptr, seq, rec_count, ovf; a clr during WRITE SHALL wait for record completion.
REQ-028 Pending flags SHALL survive clr; events continue to be captured in all states.
REQ-029 busy SHALL be high exactly while in WRITE; mem_addr/mem_din SHALL hold last values when mem_we low.

Reset
REQ-030 rst SHALL asynchronously force: FSM IDLE, mem_we 0, mem_addr BASE_ADDR, mem_din 0, busy 0, rec_count 0, ovf 0, wr_ptr 0, seq 0, pending flags 0, queued clr 0.
REQ-031 rst SHALL set synchroniser and debounced levels to 1 (released) so no press event fires after reset.
REQ-032 rst mid-WRITE SHALL abort the record; the partial slot is not counted.

Structure
REQ-033 Shared package key_bank_pkg SHALL hold the FSM state type, REC_HDR = 8'hA5, REC_BYTES = 4.
REQ-034 Debounce SHALL be one sub-module, key_debounce (one key: synchroniser, counter, level, press pulse), instantiated N_KEYS times.

Verification (DEB_CYC=4, RING_DEPTH=4, BASE_ADDR=32'h100)
REQ-035 Key 2 held low 20 cycles -> 4 writes: 0x100=A5, 0x101=02, 0x102=00, 0x103=A7; rec_count=1; bounce glitch <4 cycles -> no write.
REQ-036 Keys 0 and 3 pressed same cycle -> key 0 record at 0x100..0x103, 1 idle cycle, key 3 record at 0x104..0x107 with seq=01.
REQ-037 Five presses of key 1 -> fifth record at 0x100 (wrap), seq=04, rec_count=4.
REQ-038 Key 1 re-pressed while its first press still pending behind key 0 -> ovf=1, only one key-1 record.
REQ-039 clr asserted on 2nd byte of a record -> record completes, then rec_count=0, ovf=0, next record at 0x100 with seq=00.
REQ-040 rst asserted on 3rd byte -> outputs at reset values same cycle; next press writes at 0x100, seq=00.
